seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Parametrised multi-cycle restoring divider for the EX stage; next generation of the DIVU unit.
//  Adds signed DIV, start/done handshake, busy status, divide-by-zero flag and a WIDTH parameter.
//  Result is presented as {quotient, remainder} for the HI/LO write-back path.
//  Computes one quotient bit per cycle; the pipeline stalls on busy.
// PARAMETERS
//  WIDTH    32  operand / quotient / remainder width (>= 4)
//  CNT_W    6   iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  start      in   1        request pulse; sampled only in IDLE
//  signed_op  in   1        1 = DIV (two's complement), 0 = DIVU; sampled with start
//  dataA      in   WIDTH    dividend; sampled with start
//  dataB      in   WIDTH    divisor; sampled with start
//  busy       out  1        high from the cycle after start is accepted until done
//  done       out  1        one-cycle pulse when dataOut is updated
//  div_zero   out  1        set with done when divisor was 0; held until next accepted start
//  dataOut    out  2*WIDTH  {quotient, remainder}; holds its value until the next done
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, done=0, div_zero=0, dataOut=0; internal regs=0.
//  States: IDLE -> (start & B!=0) LOAD-into-CALC; IDLE -> (start & B==0) DONE;
//   CALC -> (cnt==WIDTH-1) FIX; FIX -> DONE; DONE -> IDLE (unconditional).
//  Accept (IDLE & start): latch |A| and |B| (magnitudes if signed_op, else raw),
//   q_neg = signed_op & (A[W-1]^B[W-1]), r_neg = signed_op & A[W-1]; cnt=0.
//  CALC, each cycle: {rem,quo} shifted left 1 bit; trial = rem - divisor (WIDTH+1 bits);
//   if trial >= 0: rem=trial, quo LSB=1; else rem unchanged, quo LSB=0. cnt++.
//  FIX: quotient negated if q_neg, remainder negated if r_neg (WIDTH-bit wrap).
//  DONE: dataOut <= {quo, rem}; done=1 for exactly this cycle; busy drops the same cycle.
//  Latency: start accepted at edge N -> done high after edge N+WIDTH+2 (34 cycles at WIDTH=32).
//  Divide by zero: no CALC; DONE at edge N+1; dataOut={ {WIDTH{1'b1}}, dataA }; div_zero=1.
//  Signed overflow MIN/-1: falls out of the datapath: quotient=MIN, remainder=0; no flag.
//  |MIN| is held as unsigned 2**(WIDTH-1); magnitude regs are WIDTH bits, no loss.
//  start while busy or in DONE: ignored, no queueing; operands not re-sampled.
//  Remainder sign follows dividend; |remainder| < |divisor| always.
//  Reset mid-operation: result discarded, no done pulse, dataOut returns to 0.
// STRUCTURE
//  Shared package div_pkg: state encoding (IDLE, CALC, FIX, DONE), DIV/DIVU opcode constants
//   (6'b011010 / 6'b011011), helper function abs_val(WIDTH).
//  Sub-module div_step: combinational single iteration
//   (rem_in, quo_in, divisor -> rem_out, quo_out); instantiated once, fed from registers.
//  Top: FSM, counter, operand/sign latches, sign-fix, output register. Decoding of the ALU
//   Signal field to start/signed_op happens in the controller, not here.
// TESTING
//  DIVU 100 / 7 -> dataOut={32'd14, 32'd2}, done exactly 34 cycles after start, busy high 33 cycles.
//  DIV -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 7 / -2 -> -3, 1.
//  DIV 0x80000000 / 0xFFFFFFFF -> {32'h80000000, 32'h0}, div_zero=0; DIVU 0xFFFFFFFF/1 -> {FFFFFFFF, 0}.
//  Any / 0 -> done 2 cycles after start, div_zero=1, dataOut={32'hFFFFFFFF, dataA}.
//  Second start 5 cycles into busy with different operands -> ignored; first result intact.
//  reset asserted at cycle 10 of CALC, deasserted, new start 9/3 -> no stale done, result {3,0}.
//  WIDTH=8 instance: random signed/unsigned sweep vs reference model, latency WIDTH+2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, opcodes, magnitude helper.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

    // ALU Signal-field opcodes; decoded to start/signed_op by the controller.
    localparam logic [5:0] OpDiv  = 6'b011010;
    localparam logic [5:0] OpDivu = 6'b011011;

    // Widest operand the magnitude helper supports.
    localparam int unsigned AbsMaxWidth = 64;

    // Two's-complement magnitude of the low `width` bits of value. The most negative
    // number comes back as its unsigned magnitude 2**(width-1).
    function automatic logic [AbsMaxWidth-1:0] abs_val(input logic [AbsMaxWidth-1:0] value,
                                                       input int unsigned width);
        logic [AbsMaxWidth-1:0] mask;
        mask = (width >= AbsMaxWidth) ? {AbsMaxWidth{1'b1}}
                                      : ({{(AbsMaxWidth-1){1'b0}}, 1'b1} << width) - 1'b1;
        if (value[width-1]) begin
            abs_val = (~value + 1'b1) & mask;
        end else begin
            abs_val = value & mask;
        end
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // Trial subtraction. If the shifted-out bit is set the partial remainder already
    // exceeds any divisor and the true difference fits in WIDTH bits, so a WIDTH-bit
    // subtraction yields the exact result.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        fits    = shifted[WIDTH] | (shifted[WIDTH-1:0] >= divisor);
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = fits ? diff : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider producing {quotient, remainder}.
module seq_divider #(
    parameter int unsigned WIDTH = 32,  // 4 .. AbsMaxWidth
    parameter int unsigned CNT_W = 6    // 2**CNT_W > WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] dataOut
);
    import div_pkg::*;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0] data_out_q, data_out_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem, step_quo;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Operand magnitudes for the accept cycle.
    always_comb begin
        a_mag = signed_op ? WIDTH'(abs_val(AbsMaxWidth'(dataA), WIDTH)) : dataA;
        b_mag = signed_op ? WIDTH'(abs_val(AbsMaxWidth'(dataB), WIDTH)) : dataB;
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        data_out_d = data_out_q;
        // Busy covers the CALC and FIX cycles; it falls together with the done pulse.
        busy_d     = (state_q == StCalc) || (state_q == StFix);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    if (dataB == '0) begin
                        // Zero divisor bypasses CALC; FIX leaves the values untouched.
                        quo_d   = '1;
                        rem_d   = dataA;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        dz_d    = 1'b1;
                        state_d = StFix;
                    end else begin
                        quo_d     = a_mag;
                        rem_d     = '0;
                        divisor_d = b_mag;
                        q_neg_d   = signed_op & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        r_neg_d   = signed_op & dataA[WIDTH-1];
                        dz_d      = 1'b0;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (q_neg_q) quo_d = -quo_q;
                if (r_neg_q) rem_d = -rem_q;
                state_d = StDone;
            end
            StDone: begin
                data_out_d = {quo_q, rem_q};
                done_d     = 1'b1;
                div_zero_d = dz_q;
                state_d    = StIdle;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            data_out_q <= data_out_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign dataOut  = data_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: directed WIDTH=32 cases plus a random WIDTH=8 sweep.
module tb_seq_divider;

    logic        clk;
    logic        reset;

    logic        start32, sop32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dz32;
    logic [63:0] out32;

    logic        start8, sop8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [15:0] out8;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(32), .CNT_W(6)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .start     (start32),
        .signed_op (sop32),
        .dataA     (a32),
        .dataB     (b32),
        .busy      (busy32),
        .done      (done32),
        .div_zero  (dz32),
        .dataOut   (out32)
    );

    seq_divider #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .signed_op (sop8),
        .dataA     (a8),
        .dataB     (b8),
        .busy      (busy8),
        .done      (done8),
        .div_zero  (dz8),
        .dataOut   (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division with remainder sign following the dividend;
    // zero divisor yields {all ones, dividend}.
    function automatic void ref_div(input int unsigned w, input logic [63:0] a,
                                    input logic [63:0] b, input bit s,
                                    output logic [63:0] q, output logic [63:0] r);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        if (b == 64'd0) begin
            q = mask;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'(a << (64 - w)) >>> (64 - w);
            sb = longint'(b << (64 - w)) >>> (64 - w);
            q  = sa / sb;
            r  = sa % sb;
        end
        q = q & mask;
        r = r & mask;
    endfunction

    // Issue one op on the 32-bit DUT; lat counts edges from acceptance to done (-1 on timeout).
    // If inj > 0, a conflicting start is pulsed inj cycles into the operation.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s, input int inj,
                         output logic [63:0] res, output int lat, output int busy_cnt,
                         output logic dz);
        @(posedge clk); #1;
        start32 = 1'b1; a32 = a; b32 = b; sop32 = s;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (busy32) busy_cnt++;
            if (done32) begin
                lat = i;
                break;
            end
            if (inj > 0 && i == inj) begin
                start32 = 1'b1; a32 = 32'd5; b32 = 32'd5; sop32 = 1'b0;
            end else if (inj > 0 && i == inj + 1) begin
                start32 = 1'b0;
            end
        end
        res = out32;
        dz  = dz32;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s,
                        output logic [15:0] res, output int lat, output logic dz);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = a; b8 = b; sop8 = s;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
        end
        res = out8;
        dz  = dz8;
    endtask

    // Run a 32-bit op and compare result, latency and flag against the reference.
    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit s);
        logic [63:0] res, q, r;
        int          lat, bc;
        logic        dz;
        run32(a, b, s, 0, res, lat, bc, dz);
        ref_div(32, {32'd0, a}, {32'd0, b}, s, q, r);
        check({tag, "_res"}, res, {q[31:0], r[31:0]});
        check({tag, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, "_dz"}, {63'd0, dz}, {63'd0, (b == 32'd0)});
    endtask

    initial begin
        logic [63:0] res, q, r;
        logic [15:0] res8;
        logic [7:0]  ra, rb;
        bit          rs;
        int          lat, bc, stale;
        logic        dz;

        reset = 1'b1;
        start32 = 1'b0; sop32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; sop8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy32}, 64'd0);
        check("rst_done", {63'd0, done32}, 64'd0);
        check("rst_dz", {63'd0, dz32}, 64'd0);
        check("rst_out", out32, 64'd0);
        check("rst_out8", {48'd0, out8}, 64'd0);
        reset = 1'b0;

        // DIVU 100 / 7: result, latency and busy duration.
        run32(32'd100, 32'd7, 1'b0, 0, res, lat, bc, dz);
        check("divu100_7_res", res, {32'd14, 32'd2});
        check("divu100_7_lat", 64'(lat), 64'd34);
        check("divu100_7_busy", 64'(bc), 64'd33);
        check("divu100_7_dz", {63'd0, dz}, 64'd0);

        // Result holds and done is a single-cycle pulse.
        repeat (3) @(posedge clk);
        #1;
        check("hold_out", out32, {32'd14, 32'd2});
        check("hold_done", {63'd0, done32}, 64'd0);

        op32("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("div_m7_2_const", out32, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        op32("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        check("div_7_m2_const", out32, {32'hFFFF_FFFD, 32'd1});
        op32("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("div_min_m1_const", out32, {32'h8000_0000, 32'd0});
        op32("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("divu_max_1_const", out32, {32'hFFFF_FFFF, 32'd0});
        op32("div_zero", 32'h0000_1234, 32'd0, 1'b1);
        check("div_zero_const", out32, {32'hFFFF_FFFF, 32'h0000_1234});

        // Flag held after done, cleared by the next accepted start.
        repeat (2) @(posedge clk);
        #1;
        check("dz_held", {63'd0, dz32}, 64'd1);

        // Conflicting start five cycles into the operation is ignored.
        run32(32'd1000, 32'd10, 1'b0, 5, res, lat, bc, dz);
        check("inject_res", res, {32'd100, 32'd0});
        check("inject_lat", 64'(lat), 64'd34);
        check("inject_dz", {63'd0, dz}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("inject_nosecond", out32, {32'd100, 32'd0});

        // Reset in the middle of CALC discards the operation.
        @(posedge clk); #1;
        start32 = 1'b1; a32 = 32'd50; b32 = 32'd3; sop32 = 1'b0;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy32}, 64'd0);
        check("midrst_out", out32, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) stale++;
        end
        check("midrst_nostale", 64'(stale), 64'd0);
        op32("after_rst_9_3", 32'd9, 32'd3, 1'b0);
        check("after_rst_const", out32, {32'd3, 32'd0});

        // Random sweep on the 8-bit instance, including MIN / -1 and zero divisors.
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            if (n == 0) begin
                ra = 8'h80; rb = 8'hFF; rs = 1'b1;
            end
            run8(ra, rb, rs, res8, lat, dz);
            ref_div(8, {56'd0, ra}, {56'd0, rb}, rs, q, r);
            check("rand8_res", {48'd0, res8}, {48'd0, q[7:0], r[7:0]});
            check("rand8_lat", 64'(lat), (rb == 8'd0) ? 64'd2 : 64'd10);
            check("rand8_dz", {63'd0, dz}, {63'd0, (rb == 8'd0)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
